// File: rtl/eth_pkg.sv
// Shared Ethernet header types, ethertype constants and classification helper.
package eth_pkg;

  typedef enum logic [1:0] {
    ClsOther = 2'd0,
    ClsIpv4  = 2'd1,
    ClsArp   = 2'd2,
    ClsIpv6  = 2'd3
  } eth_class_t;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHTYPE_IPV6 = 16'h86DD;
  localparam logic [15:0] ETHTYPE_VLAN = 16'h8100;

  localparam int unsigned ETH_HDR_LEN      = 14;
  localparam int unsigned ETH_VLAN_HDR_LEN = 18;

  typedef struct packed {
    logic [47:0] mac_dst;
    logic [47:0] mac_src;
    logic [15:0] eth_type;
    eth_class_t  cls;
    logic        vlan_valid;
    logic [11:0] vlan_id;
    logic        err_runt;
  } eth_hdr_t;

  function automatic eth_class_t eth_classify(input logic [15:0] eth_type);
    case (eth_type)
      ETHTYPE_IPV4: return ClsIpv4;
      ETHTYPE_ARP:  return ClsArp;
      ETHTYPE_IPV6: return ClsIpv6;
      default:      return ClsOther;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/eth_hdr_parser.sv
// Streaming Ethernet II header parser with per-class frame counters.
// Define ETH_HDR_PARSER_VLAN_EN to parse one 802.1Q tag (18-byte header).
module eth_hdr_parser
  import eth_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              main_clk,
  input  logic              main_rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic              m_hdr_valid,
  input  logic              m_hdr_ready,
  output logic [47:0]       m_mac_dst,
  output logic [47:0]       m_mac_src,
  output logic [15:0]       m_eth_type,
  output logic [1:0]        m_class,
  output logic              m_vlan_valid,
  output logic [11:0]       m_vlan_id,
  output logic              m_err_runt,
  output logic [CNT_W-1:0]  m_cnt_ipv4,
  output logic [CNT_W-1:0]  m_cnt_other
);

  localparam int unsigned Bytes = DATA_W / 8;

  typedef enum logic [1:0] {StHdr, StOut, StDrain} state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d, new_idx;
  logic        last_q, last_d;
  logic [7:0]  hdr_q [ETH_VLAN_HDR_LEN];
  logic [7:0]  hdr_d [ETH_VLAN_HDR_LEN];
  eth_hdr_t    rec_q, rec_d;
  logic        hdr_beat, hdr_done, hdr_end, is_vlan, hs;
  logic [15:0] outer_type;

  assign s_ready     = (state_q != StOut);
  assign m_hdr_valid = (state_q == StOut);
  assign hdr_beat    = s_valid && (state_q == StHdr);
  assign hs          = m_hdr_valid && m_hdr_ready;
  assign new_idx     = idx_q + 5'(Bytes);

  // Header buffer with the current beat merged in; bytes past the buffer are dropped.
  always_comb begin
    hdr_d = hdr_q;
    if (hdr_beat) begin
      for (int k = 0; k < int'(Bytes); k++) begin
        if (int'(idx_q) + k < int'(ETH_VLAN_HDR_LEN)) begin
          hdr_d[idx_q + 5'(k)] = s_data[DATA_W-1-8*k -: 8];
        end
      end
    end
  end

  assign outer_type = {hdr_d[12], hdr_d[13]};

`ifdef ETH_HDR_PARSER_VLAN_EN
  assign is_vlan = (new_idx >= 5'(ETH_HDR_LEN)) && (outer_type == ETHTYPE_VLAN);
`else
  assign is_vlan = 1'b0;
`endif

  assign hdr_done = new_idx >= (is_vlan ? 5'(ETH_VLAN_HDR_LEN) : 5'(ETH_HDR_LEN));
  assign hdr_end  = hdr_beat && (hdr_done || s_last);

  always_comb begin
    rec_d = rec_q;
    if (hdr_end) begin
      rec_d.mac_dst    = {hdr_d[0], hdr_d[1], hdr_d[2], hdr_d[3], hdr_d[4], hdr_d[5]};
      rec_d.mac_src    = {hdr_d[6], hdr_d[7], hdr_d[8], hdr_d[9], hdr_d[10], hdr_d[11]};
      rec_d.eth_type   = is_vlan ? {hdr_d[16], hdr_d[17]} : outer_type;
      rec_d.cls        = hdr_done ? eth_classify(rec_d.eth_type) : ClsOther;
      rec_d.vlan_valid = is_vlan;
      rec_d.vlan_id    = is_vlan ? {hdr_d[14][3:0], hdr_d[15]} : 12'h000;
      rec_d.err_runt   = !hdr_done;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      StHdr: begin
        if (hdr_end) begin
          state_d = StOut;
          idx_d   = '0;
          last_d  = s_last;
        end else if (hdr_beat) begin
          idx_d = new_idx;
        end
      end
      StOut: begin
        if (m_hdr_ready) begin
          state_d = last_q ? StHdr : StDrain;
        end
      end
      StDrain: begin
        if (s_valid && s_last) begin
          state_d = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) begin
      state_q <= StHdr;
      idx_q   <= '0;
      last_q  <= 1'b0;
      hdr_q   <= '{default: 8'h00};
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rec_q   <= rec_d;
      // Clearing at header end keeps uncaptured runt fields at zero for the next frame.
      if (hdr_end) begin
        hdr_q <= '{default: 8'h00};
      end else begin
        hdr_q <= hdr_d;
      end
    end
  end

  assign m_mac_dst    = rec_q.mac_dst;
  assign m_mac_src    = rec_q.mac_src;
  assign m_eth_type   = rec_q.eth_type;
  assign m_class      = rec_q.cls;
  assign m_vlan_valid = rec_q.vlan_valid;
  assign m_vlan_id    = rec_q.vlan_id;
  assign m_err_runt   = rec_q.err_runt;

  logic inc_ipv4, inc_other;
  assign inc_ipv4  = hs && (rec_q.cls == ClsIpv4);
  assign inc_other = hs && (rec_q.cls != ClsIpv4);

  sat_counter #(.CNT_W(CNT_W)) u_cnt_ipv4 (
    .clk_i  (main_clk),
    .rst_i  (main_rst),
    .inc_i  (inc_ipv4),
    .count_o(m_cnt_ipv4)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_other (
    .clk_i  (main_clk),
    .rst_i  (main_rst),
    .inc_i  (inc_other),
    .count_o(m_cnt_other)
  );

endmodule

// File: tb/tb_eth_hdr_parser.sv
// Directed bench: byte-wide parser (3-bit counters) and a 32-bit parser side by side.
module tb_eth_hdr_parser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Byte-wide instance
  logic [7:0]   s_data  = 8'h00;
  logic         s_valid = 1'b0;
  logic         s_last  = 1'b0;
  logic         m_ready = 1'b1;
  logic         s_ready, m_valid, m_vv, m_runt;
  logic [47:0]  m_dst, m_src;
  logic [15:0]  m_type;
  logic [1:0]   m_class;
  logic [11:0]  m_vid;
  logic [2:0]   cnt_ipv4, cnt_other;
  logic [127:0] rec8;
  assign rec8 = {m_dst, m_src, m_type, m_class, m_vv, m_vid, m_runt};

  eth_hdr_parser #(.DATA_W(8), .CNT_W(3)) u_dut8 (
    .main_clk    (clk),
    .main_rst    (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_last      (s_last),
    .m_hdr_valid (m_valid),
    .m_hdr_ready (m_ready),
    .m_mac_dst   (m_dst),
    .m_mac_src   (m_src),
    .m_eth_type  (m_type),
    .m_class     (m_class),
    .m_vlan_valid(m_vv),
    .m_vlan_id   (m_vid),
    .m_err_runt  (m_runt),
    .m_cnt_ipv4  (cnt_ipv4),
    .m_cnt_other (cnt_other)
  );

  // 32-bit instance
  logic [31:0] s32_data  = 32'h0;
  logic        s32_valid = 1'b0;
  logic        s32_last  = 1'b0;
  logic        m32_ready = 1'b1;
  logic        s32_ready, m32_valid, m32_vv, m32_runt;
  logic [47:0] m32_dst, m32_src;
  logic [15:0] m32_type;
  logic [1:0]  m32_class;
  logic [11:0] m32_vid;
  logic [31:0] c32_ipv4, c32_other;

  eth_hdr_parser #(.DATA_W(32), .CNT_W(32)) u_dut32 (
    .main_clk    (clk),
    .main_rst    (rst),
    .s_data      (s32_data),
    .s_valid     (s32_valid),
    .s_ready     (s32_ready),
    .s_last      (s32_last),
    .m_hdr_valid (m32_valid),
    .m_hdr_ready (m32_ready),
    .m_mac_dst   (m32_dst),
    .m_mac_src   (m32_src),
    .m_eth_type  (m32_type),
    .m_class     (m32_class),
    .m_vlan_valid(m32_vv),
    .m_vlan_id   (m32_vid),
    .m_err_runt  (m32_runt),
    .m_cnt_ipv4  (c32_ipv4),
    .m_cnt_other (c32_other)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] frm [64];

  task automatic build(input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] et, input int len);
    for (int i = 0; i < len; i++) frm[i] = 8'(i + 8'h40);
    for (int i = 0; i < 6; i++) begin
      frm[i]     = dst[47-8*i -: 8];
      frm[6 + i] = src[47-8*i -: 8];
    end
    frm[12] = et[15:8];
    frm[13] = et[7:0];
  endtask

  // Tasks start and end just after a falling edge; each beat is accepted on the rising edge.
  task automatic beat8(input logic [7:0] d, input logic last, output int stall);
    stall   = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready && stall < 50) begin
      @(negedge clk);
      stall++;
    end
    if (stall >= 50) begin
      checks++; failures++;
      $display("FAIL beat8_timeout s_ready=%0b required=1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic beat32(input int b, input logic last, output int stall);
    stall     = 0;
    s32_data  = {frm[4*b], frm[4*b+1], frm[4*b+2], frm[4*b+3]};
    s32_valid = 1'b1;
    s32_last  = last;
    while (!s32_ready && stall < 50) begin
      @(negedge clk);
      stall++;
    end
    if (stall >= 50) begin
      checks++; failures++;
      $display("FAIL beat32_timeout s_ready=%0b required=1", s32_ready);
    end
    @(negedge clk);
    s32_valid = 1'b0;
    s32_last  = 1'b0;
  endtask

  task automatic send8(input int len, output int stall0);
    int st;
    stall0 = 0;
    for (int i = 0; i < len; i++) begin
      beat8(frm[i], (i == len - 1), st);
      if (i == 0) stall0 = st;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready, m_valid} !== 2'b10) begin
      failures++; $display("FAIL reset_handshake got=%b required=10", {s_ready, m_valid});
    end
    checks++;
    if (rec8 !== 128'h0) begin
      failures++; $display("FAIL reset_record got=%h required=0", rec8);
    end
    checks++;
    if ({cnt_ipv4, cnt_other} !== 6'h0 || {c32_ipv4, c32_other} !== 64'h0) begin
      failures++; $display("FAIL reset_counters got=%h_%h required=0", cnt_ipv4, c32_ipv4);
    end
    checks++;
    if ({s32_ready, m32_valid} !== 2'b10) begin
      failures++; $display("FAIL reset_handshake32 got=%b required=10", {s32_ready, m32_valid});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ipv4;
    int st;
    build(48'h001122334455, 48'h66778899AABB, 16'h0800, 60);
    for (int i = 0; i < 60; i++) begin
      beat8(frm[i], (i == 59), st);
      if (i == 12) begin
        checks++;
        if (m_valid !== 1'b0) begin
          failures++; $display("FAIL ipv4_early_valid got=%b required=0", m_valid);
        end
      end
      if (i == 13) begin
        checks++;
        if ({m_valid, s_ready, m_class, m_runt, m_vv} !== 6'b10_01_00) begin
          failures++;
          $display("FAIL ipv4_status got=%b required=100100", {m_valid, s_ready, m_class, m_runt, m_vv});
        end
        checks++;
        if ({m_dst, m_src, m_type} !== {48'h001122334455, 48'h66778899AABB, 16'h0800}) begin
          failures++; $display("FAIL ipv4_fields got=%h %h %h", m_dst, m_src, m_type);
        end
      end
      if (i == 14) begin
        checks++;
        if (st !== 1) begin
          failures++; $display("FAIL ipv4_ready_low_cycles got=%0d required=1", st);
        end
      end
    end
    checks++;
    if ({cnt_ipv4, cnt_other} !== {3'd1, 3'd0}) begin
      failures++; $display("FAIL ipv4_counts got=%0d/%0d required=1/0", cnt_ipv4, cnt_other);
    end
  endtask

  task automatic test_arp_stall32;
    int st;
    int max_st;
    build(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h0806, 40);
    m32_ready = 1'b0;
    for (int b = 0; b < 4; b++) beat32(b, 1'b0, st);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({m32_valid, s32_ready, m32_class, m32_dst, m32_src, m32_type} !==
          {1'b1, 1'b0, 2'd2, 48'h0A0B0C0D0E0F, 48'h102030405060, 16'h0806}) begin
        failures++;
        $display("FAIL arp_hold cyc=%0d got=%b%b %0d %h %h %h", c, m32_valid, s32_ready,
                 m32_class, m32_dst, m32_src, m32_type);
      end
      @(negedge clk);
    end
    m32_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({m32_valid, s32_ready, c32_ipv4, c32_other} !== {1'b0, 1'b1, 32'd0, 32'd1}) begin
      failures++;
      $display("FAIL arp_release got=%b%b %0d/%0d required=01 0/1", m32_valid, s32_ready,
               c32_ipv4, c32_other);
    end
    max_st = 0;
    for (int b = 4; b < 10; b++) begin
      beat32(b, (b == 9), st);
      if (st > max_st) max_st = st;
    end
    checks++;
    if (max_st !== 0) begin
      failures++; $display("FAIL arp_drain_stall got=%0d required=0", max_st);
    end
    checks++;
    if ({s32_ready, m32_valid, m32_class} !== 4'b10_10) begin
      failures++; $display("FAIL arp_after_drain got=%b required=1010", {s32_ready, m32_valid, m32_class});
    end
  endtask

  task automatic test_runt;
    int st;
    build(48'hAABBCCDDEEFF, 48'h112233445566, 16'h0800, 10);
    for (int i = 0; i < 10; i++) beat8(frm[i], (i == 9), st);
    checks++;
    if ({m_valid, m_runt, m_class} !== 4'b11_00) begin
      failures++; $display("FAIL runt_status got=%b required=1100", {m_valid, m_runt, m_class});
    end
    checks++;
    if ({m_dst, m_src, m_type} !== {48'hAABBCCDDEEFF, 48'h112233440000, 16'h0000}) begin
      failures++; $display("FAIL runt_fields got=%h %h %h", m_dst, m_src, m_type);
    end
    @(negedge clk);
    checks++;
    if ({cnt_ipv4, cnt_other} !== {3'd1, 3'd1}) begin
      failures++; $display("FAIL runt_counts got=%0d/%0d required=1/1", cnt_ipv4, cnt_other);
    end
    build(48'h0000000000AA, 48'h0000000000BB, 16'h0806, 20);
    send8(20, st);
    checks++;
    if ({m_class, m_runt, m_type, m_dst, cnt_other} !==
        {2'd2, 1'b0, 16'h0806, 48'h0000000000AA, 3'd2}) begin
      failures++;
      $display("FAIL runt_next_frame got=%0d %b %h %h %0d", m_class, m_runt, m_type, m_dst, cnt_other);
    end
  endtask

  task automatic test_vlan;
    int st;
    build(48'h0C0000000001, 48'h0C0000000002, 16'h8100, 30);
    frm[14] = 8'h01;
    frm[15] = 8'h23;
    frm[16] = 8'h86;
    frm[17] = 8'hDD;
    for (int i = 0; i < 30; i++) begin
      beat8(frm[i], (i == 29), st);
`ifdef ETH_HDR_PARSER_VLAN_EN
      if (i == 13) begin
        checks++;
        if (m_valid !== 1'b0) begin
          failures++; $display("FAIL vlan_early_valid got=%b required=0", m_valid);
        end
      end
      if (i == 17) begin
        checks++;
        if ({m_valid, m_vv, m_vid, m_class, m_type, m_runt} !==
            {1'b1, 1'b1, 12'h123, 2'd3, 16'h86DD, 1'b0}) begin
          failures++;
          $display("FAIL vlan_record got=%b%b %h %0d %h %b", m_valid, m_vv, m_vid, m_class,
                   m_type, m_runt);
        end
      end
`else
      if (i == 13) begin
        checks++;
        if ({m_valid, m_vv, m_vid, m_class, m_type} !== {1'b1, 1'b0, 12'h0, 2'd0, 16'h8100}) begin
          failures++;
          $display("FAIL vlan_disabled got=%b%b %h %0d %h", m_valid, m_vv, m_vid, m_class, m_type);
        end
      end
`endif
    end
    checks++;
    if (cnt_other !== 3'd3) begin
      failures++; $display("FAIL vlan_count got=%0d required=3", cnt_other);
    end
  endtask

  task automatic test_reset_mid;
    int st;
    build(48'h0E0E0E0E0E0E, 48'h0F0F0F0F0F0F, 16'h0800, 14);
    for (int i = 0; i < 7; i++) beat8(frm[i], 1'b0, st);
    rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, m_valid, rec8, cnt_ipv4, cnt_other} !== {2'b10, 128'h0, 6'h0}) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b%b %h %0d/%0d", s_ready, m_valid, rec8,
               cnt_ipv4, cnt_other);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    build(48'h020000000001, 48'h020000000002, 16'h0800, 14);
    send8(14, st);
    @(negedge clk);
    checks++;
    if ({m_class, m_dst, m_src, cnt_ipv4, cnt_other} !==
        {2'd1, 48'h020000000001, 48'h020000000002, 3'd1, 3'd0}) begin
      failures++;
      $display("FAIL reset_mid_clean got=%0d %h %h %0d/%0d", m_class, m_dst, m_src,
               cnt_ipv4, cnt_other);
    end
    checks++;
    if ({s_ready, m_valid} !== 2'b10) begin
      failures++; $display("FAIL reset_mid_idle got=%b required=10", {s_ready, m_valid});
    end
  endtask

  task automatic test_saturate;
    int st;
    int exp;
    build(48'h0A0000000001, 48'h0A0000000002, 16'h0800, 14);
    for (int f = 0; f < 7; f++) begin
      send8(14, st);
      @(negedge clk);
      exp = (f + 2 > 7) ? 7 : f + 2;
      checks++;
      if (cnt_ipv4 !== 3'(exp)) begin
        failures++; $display("FAIL saturate_frame%0d got=%0d required=%0d", f, cnt_ipv4, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    int st;
    build(48'h0B0000000001, 48'h0B0000000002, 16'h0806, 14);
    send8(14, st);
    send8(14, st);
    checks++;
    if (st !== 1) begin
      failures++; $display("FAIL b2b_bubble got=%0d required=1", st);
    end
    @(negedge clk);
    checks++;
    if ({cnt_ipv4, cnt_other, m_class} !== {3'd7, 3'd2, 2'd2}) begin
      failures++;
      $display("FAIL b2b_counts got=%0d/%0d cls=%0d required=7/2 cls=2", cnt_ipv4, cnt_other, m_class);
    end
  endtask

  initial begin
    test_reset();
    test_ipv4();
    test_arp_stall32();
    test_runt();
    test_vlan();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end

endmodule
